// File: rtl/secuenciador_parametros.sv
// Address sequencer feeding the parameter-enable decoder: walks addresses
// 0..N_PARAM-1 with one write handshake each, then presents the ready code.
module secuenciador_parametros #(
  parameter int unsigned N_PARAM = 9,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       done_wr,
  output logic [3:0] addr,
  output logic       en,
  output logic       wr_req,
  output logic       busy,
  output logic       fin,
  output logic       error
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, LISTO, ERR} state_t;

  localparam logic [3:0] LAST_ADDR  = 4'(N_PARAM - 1);
  localparam logic [3:0] READY_ADDR = 4'(N_PARAM);
  localparam logic [7:0] TMO_SAT    = 8'(TIMEOUT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr   <= '0;
      en     <= 1'b0;
      wr_req <= 1'b0;
      busy   <= 1'b0;
      fin    <= 1'b0;
      error  <= 1'b0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (start) begin
            state  <= REQ;
            addr   <= '0;
            en     <= 1'b1;
            wr_req <= 1'b1;
            busy   <= 1'b1;
            error  <= 1'b0;
          end
        end
        REQ: begin
          state  <= WAIT;
          wr_req <= 1'b0;
          cnt    <= '0;
        end
        WAIT: begin
          // An acknowledge on the final counted cycle still wins over timeout.
          if (done_wr) begin
            if (addr == LAST_ADDR) begin
              state <= LISTO;
              addr  <= READY_ADDR;
              fin   <= 1'b1;
            end else begin
              state  <= REQ;
              addr   <= addr + 4'd1;
              wr_req <= 1'b1;
            end
          end else if (cnt == TMO_LAST) begin
            state <= ERR;
            addr  <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
            error <= 1'b1;
          end
          if (cnt != TMO_SAT) cnt <= cnt + 8'd1;
        end
        LISTO: begin
          state <= IDLE;
          addr  <= '0;
          en    <= 1'b0;
          fin   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          addr   <= '0;
          en     <= 1'b0;
          wr_req <= 1'b0;
          busy   <= 1'b0;
          fin    <= 1'b0;
        end
      endcase
    end
  end

endmodule
